// File: rtl/multi_mode_ring_counter.sv
// Ring / Johnson counter with selectable rotation direction, parallel load,
// self-correction of illegal states, a registered wrap pulse and a
// combinational illegal-state flag.
module multi_mode_ring_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

  logic [CW-1:0]    ones;
  logic [CW-1:0]    edges;
  logic             ring_ok;
  logic             john_ok;
  logic             legal;
  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_out;
  logic             next_tc;

  // Legality of the current state under the current mode: one-hot for ring,
  // a single circular run of ones (0 or 2 bit transitions) for Johnson.
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones  = ones + CW'(out[i]);
      edges = edges + CW'(out[i] ^ out[(i + 1) % WIDTH]);
    end
    ring_ok = (ones == CW'(1));
    john_ok = (edges == CW'(0)) || (edges == CW'(2));
    legal   = mode ? john_ok : ring_ok;
    err     = ~legal;
  end

  // Next state: load beats en beats hold; an illegal state steps to the seed.
  always_comb begin
    fb       = 1'b0;
    shifted  = out;
    next_out = out;
    next_tc  = 1'b0;
    if (dir) begin
      fb      = mode ? ~out[WIDTH-1] : out[WIDTH-1];
      shifted = {out[WIDTH-2:0], fb};
    end else begin
      fb      = mode ? ~out[0] : out[0];
      shifted = {fb, out[WIDTH-1:1]};
    end
    if (load) begin
      next_out = load_val;
    end else if (en) begin
      if (!legal) begin
        next_out = SEED;
      end else begin
        next_out = shifted;
        next_tc  = (shifted == SEED);
      end
    end
  end

  // State and wrap-pulse registers; reset forces the seed immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= SEED;
      tc  <= 1'b0;
    end else begin
      out <= next_out;
      tc  <= next_tc;
    end
  end

endmodule
